// File: rtl/dsp_result_capture.sv
// +----------------------------------------------------------------------------+
// | dsp_result_capture: credit-controlled issue and result capture for a       |
// | CE-gated DSP48A1 pipeline, with an in-order result FIFO.                    |
// | Optional macro: DSP_CAPTURE_FLUSH_EN (adds synchronous flush input).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dsp_result_capture #(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DSP_CAPTURE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce,
  input  logic [WIDTH-1:0] res_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = ((CW > 5) ? CW : 5) + 1;

  logic [LATENCY-1:0] r_vld;
  logic [4:0]         r_inflight;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_wr;
  logic          w_pop;
  logic [SW-1:0] w_occ;
  logic          w_clear;

  // Credit counts both buffered and in-flight results, so the FIFO cannot overflow.
  assign w_occ = SW'(r_cnt) + SW'(r_inflight);
`ifdef DSP_CAPTURE_FLUSH_EN
  assign w_clear  = flush;
`else
  assign w_clear  = 1'b0;
`endif
  assign in_ready = (w_occ < SW'(DEPTH)) && !w_clear;
  assign w_accept = in_valid && in_ready;
  assign ce       = w_accept || (r_inflight != 5'd0);
  assign w_wr     = r_vld[LATENCY-1];
  assign w_pop    = out_valid && out_ready;

  assign out_valid = (r_cnt != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign inflight  = r_inflight;

  generate
    if (LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_vld <= '0;
        else if (w_clear) r_vld <= '0;
        else if (ce)      r_vld <= w_accept;
      end
    end else begin : g_vld_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_vld <= '0;
        else if (w_clear) r_vld <= '0;
        else if (ce)      r_vld <= {r_vld[LATENCY-2:0], w_accept};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 5'd0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (w_clear) begin
      r_inflight <= 5'd0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= r_inflight + 5'(w_accept) - 5'(w_wr);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is deliberately left unreset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (w_wr && !w_clear) r_mem[r_wr_ptr] <= res_in;
  end

endmodule

`default_nettype wire

// File: tb/tb_dsp_result_capture.sv
// +----------------------------------------------------------------------------+
// | tb_dsp_result_capture: randomized bench with a queue-based reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dsp_result_capture;

  localparam int W = 48;
  localparam int L = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] res_in = '0;
  logic         in_ready, ce, out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   inflight;
  logic         flush = 1'b0;

  dsp_result_capture #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DSP_CAPTURE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ce        (ce),
    .res_in    (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: results waiting in the slice (with due cycle) and results buffered.
  logic [W-1:0] pipe_val[$];
  int           pipe_due[$];
  logic [W-1:0] fifo_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd48();
    return {$urandom(), $urandom()} & {W{1'b1}};
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit iv, input bit ordy, input bit fl, output bit dut_acc);
    logic [W-1:0] val;
    bit exp_rdy, acc, exp_ov;
    val       = rnd48();
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    res_in    = rnd48();
    if (pipe_due.size() > 0 && pipe_due[0] == cyc) res_in = pipe_val[0];
    @(negedge clk);
    exp_rdy = !fl && ((fifo_q.size() + pipe_due.size()) < D);
    acc     = iv && exp_rdy;
    exp_ov  = fifo_q.size() > 0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("ce", 64'(ce), 64'(acc || pipe_due.size() > 0));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("inflight", 64'(inflight), 64'(pipe_due.size()));
    if (exp_ov) check("out_data", 64'(out_data), 64'(fifo_q[0]));
    dut_acc = iv && in_ready;
    @(posedge clk);
    if (fl) begin
      fifo_q.delete();
      pipe_val.delete();
      pipe_due.delete();
    end else begin
      if (exp_ov && ordy) void'(fifo_q.pop_front());
      if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
        fifo_q.push_back(pipe_val.pop_front());
        void'(pipe_due.pop_front());
      end
      if (acc) begin
        pipe_val.push_back(val);
        pipe_due.push_back(cyc + L);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input bit iv, input bit ordy, output int n_acc);
    bit a;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      step(iv, ordy, 1'b0, a);
      n_acc += int'(a);
    end
  endtask

  task automatic async_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ce", 64'(ce), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    fifo_q.delete();
    pipe_val.delete();
    pipe_due.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int n;
    bit a;
    int first_ov;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_ce", 64'(ce), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_inflight", 64'(inflight), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: first out_valid must appear LATENCY+1 cycles after issue.
    run(4, 1'b0, 1'b1, n);
    step(1'b1, 1'b1, 1'b0, a);
    first_ov = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b0, a);
      if (first_ov < 0 && out_valid) first_ov = i;
    end
    check("single_latency", 64'(first_ov), 64'(L));

    // Back-to-back stream with a free-running consumer.
    run(20, 1'b1, 1'b1, n);
    check("b2b_accepts", 64'(n), 64'd20);
    run(8, 1'b0, 1'b1, n);

    // Stalled consumer: exactly DEPTH ops accepted.
    run(14, 1'b1, 1'b0, n);
    check("fill_accepts", 64'(n), 64'(D));
    step(1'b1, 1'b1, 1'b0, a);
    check("full_pop_no_accept", 64'(a), 64'd0);
    run(6, 1'b1, 1'b0, n);
    check("refill_accepts", 64'(n), 64'd1);
    run(14, 1'b0, 1'b1, n);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 3) != 0, 1'b0, a);
    run(14, 1'b0, 1'b1, n);

    // Asynchronous reset with 2 buffered, 3 in flight.
    run(5, 1'b1, 1'b0, n);
    run(1, 1'b0, 1'b0, n);
    check("pre_rst_inflight", 64'(inflight), 64'd3);
    async_reset();
    run(2, 1'b0, 1'b1, n);
    step(1'b1, 1'b1, 1'b0, a);
    run(10, 1'b0, 1'b1, n);

`ifdef DSP_CAPTURE_FLUSH_EN
    // Flush with 5 buffered, 2 in flight; late results must not appear.
    run(7, 1'b1, 1'b0, n);
    run(2, 1'b0, 1'b0, n);
    step(1'b1, 1'b0, 1'b1, a);
    check("flush_no_accept", 64'(a), 64'd0);
    run(10, 1'b0, 1'b1, n);
    for (int i = 0; i < 100; i++)
      step(($urandom % 2) != 0, ($urandom % 2) != 0, ($urandom % 17) == 0, a);
    run(14, 1'b0, 1'b1, n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
